// File: rtl/interconexion_param_if.sv
// ============================================================================
// interconexion_param_if : bus bundle between the crossbar and its client
// Rev 1.0
// ============================================================================
`default_nettype none

interface interconexion_param_if #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int N_CH   = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic [N_CH*DATA_W-1:0] fifo_i;
  logic [N_CH-1:0]        push;
  logic [N_CH-1:0]        pop;
  logic                   modo;
  logic [c_CW-1:0]        umbral_af;
  logic [N_CH*DATA_W-1:0] fifo_out;
  logic [N_CH-1:0]        full_in;
  logic [N_CH-1:0]        empty_out;
  logic [N_CH-1:0]        af_out;
  logic [N_CH-1:0]        err_ovf;
  logic [N_CH-1:0]        err_udf;
  logic                   idle;

  modport master (
    output fifo_i, push, pop, modo, umbral_af,
    input  fifo_out, full_in, empty_out, af_out, err_ovf, err_udf, idle
  );

  modport slave (
    input  fifo_i, push, pop, modo, umbral_af,
    output fifo_out, full_in, empty_out, af_out, err_ovf, err_udf, idle
  );
endinterface

`default_nettype wire

// File: rtl/interconexion_param.sv
// ============================================================================
// interconexion_param : N_CH input FIFOs routed by header bits to N_CH outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module interconexion_param #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int N_CH   = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  interconexion_param_if.slave  bus
);
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_SW = $clog2(N_CH);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mem_in  [N_CH][DEPTH];
  logic [DATA_W-1:0] r_mem_out [N_CH][DEPTH];
  logic [c_PW-1:0]   r_wp_in [N_CH], r_rp_in [N_CH];
  logic [c_PW-1:0]   r_wp_out[N_CH], r_rp_out[N_CH];
  logic [c_CW-1:0]   r_cnt_in[N_CH], r_cnt_out[N_CH];
  logic [c_CW-1:0]   r_thr;
  logic [c_SW-1:0]   r_last;
  logic [N_CH-1:0]   r_ovf, r_udf;

  logic [DATA_W-1:0] w_head_in [N_CH];
  logic [c_SW-1:0]   w_dest    [N_CH];
  logic [N_CH-1:0]   w_empty_in, w_full_in, w_empty_out, w_full_out, w_af;
  logic [N_CH-1:0]   w_elig, w_pop_in, w_push_ok, w_wr_out, w_pop_ok;
  logic [c_SW-1:0]   w_grant, w_idx, w_xfer_dest;
  logic [DATA_W-1:0] w_xfer_word;
  logic              w_found, w_xfer, w_in_busy;
  logic [N_CH*DATA_W-1:0] w_fifo_out;

  always_comb begin
    w_empty_in  = '0;
    w_full_in   = '0;
    w_empty_out = '0;
    w_full_out  = '0;
    w_af        = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_head_in[k]   = r_mem_in[k][r_rp_in[k]];
      w_dest[k]      = w_head_in[k][DATA_W-1 -: c_SW];
      w_empty_in[k]  = (r_cnt_in[k] == '0);
      w_full_in[k]   = (r_cnt_in[k] == c_CW'(DEPTH));
      w_empty_out[k] = (r_cnt_out[k] == '0);
      w_full_out[k]  = (r_cnt_out[k] == c_CW'(DEPTH));
      w_af[k]        = (r_cnt_out[k] >= r_thr);
    end
  end

  // The full check only matters for thresholds above DEPTH, which af never reaches.
  always_comb begin
    w_elig  = '0;
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N_CH; k++)
      w_elig[k] = !w_empty_in[k] && !w_af[w_dest[k]] && !w_full_out[w_dest[k]];
    for (int i = 0; i < N_CH; i++) begin
      w_idx = bus.modo ? c_SW'(i) : (r_last + c_SW'(1) + c_SW'(i));
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_xfer      = (r_state == S_ACTIVE) && w_found;
    w_xfer_word = w_head_in[w_grant];
    w_xfer_dest = w_dest[w_grant];
    w_pop_in    = '0;
    w_push_ok   = '0;
    w_wr_out    = '0;
    w_pop_ok    = '0;
    w_in_busy   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      w_pop_in[k]  = w_xfer && (w_grant == c_SW'(k));
      w_push_ok[k] = bus.push[k] && (!w_full_in[k] || w_pop_in[k]);
      w_wr_out[k]  = w_xfer && (w_xfer_dest == c_SW'(k));
      w_pop_ok[k]  = bus.pop[k] && !w_empty_out[k];
      if ((r_cnt_in[k] + c_CW'(w_push_ok[k]) - c_CW'(w_pop_in[k])) != '0)
        w_in_busy = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   w_state_nxt = S_IDLE;
      S_IDLE:   if (!(&w_empty_in)) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_xfer && !w_in_busy) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_thr   <= c_CW'(DEPTH);
      r_last  <= c_SW'(N_CH - 1);
      r_ovf   <= '0;
      r_udf   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_wp_in[k]   <= '0;
        r_rp_in[k]   <= '0;
        r_cnt_in[k]  <= '0;
        r_wp_out[k]  <= '0;
        r_rp_out[k]  <= '0;
        r_cnt_out[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT)
        r_thr <= (bus.umbral_af == '0) ? c_CW'(DEPTH) : bus.umbral_af;
      if (w_xfer)
        r_last <= w_grant;
      r_ovf <= r_ovf | (bus.push & ~w_push_ok);
      r_udf <= r_udf | (bus.pop & w_empty_out);
      for (int k = 0; k < N_CH; k++) begin
        if (w_push_ok[k]) r_wp_in[k]  <= r_wp_in[k] + c_PW'(1);
        if (w_pop_in[k])  r_rp_in[k]  <= r_rp_in[k] + c_PW'(1);
        if (w_wr_out[k])  r_wp_out[k] <= r_wp_out[k] + c_PW'(1);
        if (w_pop_ok[k])  r_rp_out[k] <= r_rp_out[k] + c_PW'(1);
        r_cnt_in[k]  <= r_cnt_in[k] + c_CW'(w_push_ok[k]) - c_CW'(w_pop_in[k]);
        r_cnt_out[k] <= r_cnt_out[k] + c_CW'(w_wr_out[k]) - c_CW'(w_pop_ok[k]);
      end
    end
  end

  // Storage needs no reset: occupancy counts alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (w_push_ok[k]) r_mem_in[k][r_wp_in[k]]   <= bus.fifo_i[k*DATA_W +: DATA_W];
      if (w_wr_out[k])  r_mem_out[k][r_wp_out[k]] <= w_xfer_word;
    end
  end

  always_comb begin
    w_fifo_out = '0;
    for (int k = 0; k < N_CH; k++)
      w_fifo_out[k*DATA_W +: DATA_W] = w_empty_out[k] ? '0 : r_mem_out[k][r_rp_out[k]];
  end

  assign bus.fifo_out  = w_fifo_out;
  assign bus.full_in   = w_full_in;
  assign bus.empty_out = w_empty_out;
  assign bus.af_out    = w_af;
  assign bus.err_ovf   = r_ovf;
  assign bus.err_udf   = r_udf;
  assign bus.idle      = (r_state == S_IDLE);

endmodule

`default_nettype wire
